tpu_output_drain: RTL
=====================

# tpu_output_drain

Output stage directly downstream of the TPU controller and systolic array. On each new result event it captures the N column accumulators (INT32) in parallel, requantizes each to INT8 with a rounding arithmetic right shift and saturation, and streams them out one element per transfer on a valid/ready interface. It decouples the array from a slower result consumer (writeback buffer or host port).

## Interface
- N, 8, number of array columns / accumulators captured per event (≥2)
- ACC_W, 32, accumulator width (signed)
- OUT_W, 8, output element width (signed)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- acc_in  in  N*ACC_W  flattened accumulators; element i at bits [i*ACC_W +: ACC_W]
- acc_valid  in  1  result-ready level from controller; event = 0→1 transition
- shift  in  5  requant right-shift amount 0..31, sampled at capture
- out_data  out  OUT_W  requantized signed element
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when high with out_valid
- out_index  out  $clog2(N)  index of current element
- out_last  out  1  high with the element at index N-1
- busy  out  1  capture buffer occupied (state DRAIN)
- drain_done  out  1  one-cycle pulse after last element transferred
- overrun  out  1  sticky: event arrived while busy; cleared only by rst

## Operation
- States: IDLE, DRAIN.
- Edge detect: acc_valid_q registers acc_valid; event = acc_valid & ~acc_valid_q. A level held high is one event.
- IDLE: on event, latch all N words of acc_in and shift into capture registers, idx←0, go DRAIN.
- DRAIN: out_valid=1, out_index=idx, out_data=requant(cap[idx], shift_q). Transfer = out_valid & out_ready. On transfer with idx<N-1: idx←idx+1. On transfer with idx=N-1: go IDLE, drain_done pulses next cycle.
- Event while in DRAIN (including the cycle of the final transfer): discarded, capture registers unchanged, overrun←1.
- Requant: shift_q=0 → v=acc. Else v = (acc + 2^(shift_q-1)) >>> shift_q, computed in ACC_W+1 bits signed (no overflow on the rounding add). Result saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- out_data/out_index/out_last stable while out_valid & ~out_ready.
- Reset values: state IDLE, idx 0, acc_valid_q 0, out_valid 0, out_data 0, out_index 0, out_last 0, busy 0, drain_done 0, overrun 0. Capture registers need no reset.
- rst mid-drain: remaining elements dropped, outputs go to reset values next cycle. acc_valid high at reset release counts as an event.

## Timing
- Event at edge k (captured) → out_valid high from cycle k+1; first element available 1 cycle after event.
- With out_ready held high: N elements on N consecutive cycles, drain_done pulse in cycle after last, next event accepted from that cycle. Minimum event spacing N+1 cycles.
- busy = (state==DRAIN); equals out_valid.
- Requant path is combinational from capture registers to out_data within one cycle; no extra pipeline stage.

## Structure
- Shared package tpu_pkg: ACC_W/OUT_W defaults, INT8 min/max constants, requant function (shared with any future bias/requant stage).
- One sub-module natural: tpu_requant (combinational round-shift-saturate, parameterized ACC_W/OUT_W), instantiated once on the muxed element.

## Test plan
- Basic drain: N=8, acc_in = {0,1,…,7}·16, shift=4, out_ready=1 → out_data 0..7 on 8 consecutive cycles, out_last at index 7, drain_done next cycle.
- Rounding/saturation: acc=23 shift=1 → 12; acc=-23 shift=1 → -11; acc=100000 shift=0 → 127; acc=-100000 shift=0 → -128; acc=0x7FFFFFFF shift=31 → 1.
- Backpressure: out_ready low 3 cycles at index 2 → out_data/out_index hold value of element 2, no skip or duplicate; all 8 elements delivered in order.
- Overrun: second rising acc_valid during DRAIN → overrun=1 and stays 1, output sequence still the first capture's values; acc_valid held high across drain → no second drain, overrun 0.
- Reset mid-drain: assert rst at index 4 → next cycle out_valid=0, busy=0, idx 0; new event then drains from index 0.
- Back-to-back: event at earliest accepted cycle after drain_done → second drain starts next cycle, no overrun.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU datapath types, widths and the INT32->INT8 requantization function.
package tpu_pkg;

  localparam int unsigned TPU_ACC_W   = 32;
  localparam int unsigned TPU_OUT_W   = 8;
  localparam int unsigned TPU_SHIFT_W = 5;

  localparam logic signed [TPU_OUT_W-1:0] INT8_MAX = 8'sd127;
  localparam logic signed [TPU_OUT_W-1:0] INT8_MIN = -8'sd128;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  // Round-half-up arithmetic shift followed by INT8 saturation (default widths).
  function automatic logic signed [TPU_OUT_W-1:0] requant(
    input logic signed [TPU_ACC_W-1:0]   acc,
    input logic        [TPU_SHIFT_W-1:0] sh
  );
    logic signed [TPU_ACC_W:0] v;
    logic signed [TPU_ACC_W:0] rnd;
    v   = $signed({acc[TPU_ACC_W-1], acc});
    rnd = '0;
    if (sh != '0) begin
      rnd = (TPU_ACC_W + 1)'(1) << (sh - TPU_SHIFT_W'(1));
    end
    v = (v + rnd) >>> sh;
    if (v > (TPU_ACC_W + 1)'(INT8_MAX)) begin
      return INT8_MAX;
    end
    if (v < (TPU_ACC_W + 1)'(INT8_MIN)) begin
      return INT8_MIN;
    end
    return v[TPU_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/tpu_requant.sv
// Combinational round-shift-saturate of one signed accumulator to a narrow signed element.
module tpu_requant
  import tpu_pkg::*;
#(
  parameter int unsigned ACC_W   = TPU_ACC_W,
  parameter int unsigned OUT_W   = TPU_OUT_W,
  parameter int unsigned SHIFT_W = TPU_SHIFT_W
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   data_c
);

  // One extra bit so the rounding add can never overflow.
  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] shifted;

  // Add half an LSB of the result, shift arithmetically, then clamp.
  always_comb begin
    acc_ext = $signed({acc[ACC_W-1], acc});
    rnd     = '0;
    if (shift != '0) begin
      rnd = EXT_W'(1) << (shift - SHIFT_W'(1));
    end
    shifted = (acc_ext + rnd) >>> shift;
    if (shifted > SAT_MAX) begin
      data_c = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      data_c = SAT_MIN[OUT_W-1:0];
    end else begin
      data_c = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/tpu_output_drain.sv
// Captures N column accumulators on a result event and streams them out requantized, one per transfer.
module tpu_output_drain
  import tpu_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned ACC_W = TPU_ACC_W,
  parameter int unsigned OUT_W = TPU_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*ACC_W-1:0]      acc_in,
  input  logic                    acc_valid,
  input  logic [TPU_SHIFT_W-1:0]  shift,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(N)-1:0]    out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    drain_done,
  output logic                    overrun
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  drain_state_e            state_q;
  drain_state_e            state_d;
  logic [IDX_W-1:0]        idx_q;
  logic                    acc_valid_q;
  logic [N*ACC_W-1:0]      cap_q;
  logic [TPU_SHIFT_W-1:0]  shift_q;
  logic                    drain_done_q;
  logic                    overrun_q;

  logic                    evt_c;
  logic                    xfer_c;
  logic                    capture_c;
  logic [ACC_W-1:0]        elem_c;
  logic [OUT_W-1:0]        req_c;

  assign evt_c  = acc_valid & ~acc_valid_q;
  assign xfer_c = out_valid & out_ready;
  assign elem_c = cap_q[idx_q*ACC_W +: ACC_W];

  assign drain_done = drain_done_q;
  assign overrun    = overrun_q;

  tpu_requant #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (TPU_SHIFT_W)
  ) u_requant (
    .acc    (elem_c),
    .shift  (shift_q),
    .data_c (req_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start a drain on an event, return to idle after the last element transfers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (evt_c) state_d = ST_DRAIN;
      ST_DRAIN: if (xfer_c && (idx_q == LAST_IDX)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Stream outputs decoded from state; out_data is the requantized element at idx.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_index = '0;
    out_last  = 1'b0;
    out_data  = '0;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: capture_c = evt_c;
      ST_DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_index = idx_q;
        out_last  = (idx_q == LAST_IDX);
        out_data  = req_c;
      end
      default: ;
    endcase
  end

  // Edge detector, element index, completion pulse and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_valid_q  <= 1'b0;
      idx_q        <= '0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      acc_valid_q  <= acc_valid;
      drain_done_q <= xfer_c && (idx_q == LAST_IDX);
      if (evt_c && (state_q == ST_DRAIN)) begin
        overrun_q <= 1'b1;
      end
      if (capture_c) begin
        idx_q <= '0;
      end else if (xfer_c) begin
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Capture buffer; holds its contents for the whole drain, events during a drain are ignored.
  always_ff @(posedge clk) begin
    if (capture_c) begin
      cap_q   <= acc_in;
      shift_q <= shift;
    end
  end

endmodule
